// File: rtl/bram_gather_pkg.sv
// rtl/bram_gather_pkg.sv - shared types and address/lane helpers for the lane gather block
package bram_gather_pkg;

    localparam int ADDR_W     = 40;
    localparam int LANES      = 8;
    localparam int LINE_BYTES = 16;
    localparam int LINE_W     = ADDR_W - 4;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        RD_ISSUE,
        RD_WAIT
    } state_t;

    function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:4];
    endfunction

    function automatic logic [2:0] lane_of(input logic [ADDR_W-1:0] addr);
        return addr[3:1];
    endfunction

    function automatic logic [LINE_BYTES-1:0] strobe_mask(input logic [1:0] we,
                                                          input logic [2:0] lane);
        return {14'd0, we} << {lane, 1'b0};
    endfunction

    // Narrow write data is replicated across the line; the byte mask picks the target lane.
    function automatic logic [8*LINE_BYTES-1:0] byte_merge(input logic [8*LINE_BYTES-1:0] old,
                                                           input logic [15:0] wdata,
                                                           input logic [LINE_BYTES-1:0] mask);
        logic [8*LINE_BYTES-1:0] r;
        r = old;
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (mask[b]) r[8*b +: 8] = wdata[8*(b % 2) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_gather_wbuf.sv
// rtl/bram_gather_wbuf.sv - one-line write-merge buffer with byte mask and full detect
module bram_gather_wbuf
    import bram_gather_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    merge,
    input  logic                    clear,
    input  logic [LINE_W-1:0]       wr_line,
    input  logic [2:0]              wr_lane,
    input  logic [1:0]              wr_we,
    input  logic [15:0]             wr_data,
    output logic                    buf_valid,
    output logic [LINE_W-1:0]       buf_line,
    output logic [8*LINE_BYTES-1:0] buf_data,
    output logic [LINE_BYTES-1:0]   buf_mask,
    output logic                    full_next
);

    logic [LINE_BYTES-1:0] lane_mask;
    logic [LINE_BYTES-1:0] mask_next;

    assign lane_mask = strobe_mask(wr_we, wr_lane);
    assign mask_next = buf_mask | lane_mask;
    assign full_next = &mask_next;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            buf_valid <= 1'b0;
            buf_mask  <= '0;
        end else if (clear) begin
            buf_valid <= 1'b0;
            buf_mask  <= '0;
        end else if (merge) begin
            buf_valid <= 1'b1;
            buf_line  <= wr_line;
            buf_mask  <= mask_next;
            buf_data  <= byte_merge(buf_data, wr_data, lane_mask);
        end
    end

endmodule

// File: rtl/bram_lane_gather.sv
// rtl/bram_lane_gather.sv - 16-bit request port gathered onto 128-bit BRAM lines
module bram_lane_gather
    import bram_gather_pkg::*;
#(
    parameter int ADDR_WIDTH        = 40,
    parameter int WIDE_DATA_WIDTH   = 128,
    parameter int NARROW_DATA_WIDTH = 16,
    parameter int READ_LATENCY      = 1
) (
    input  logic                         bram_clk_in,
    input  logic                         bram_rstn_in,
    input  logic                         req_valid_in,
    output logic                         req_ready_out,
    input  logic [1:0]                   req_we_in,
    input  logic [ADDR_WIDTH-1:0]        req_addr_in,
    input  logic [NARROW_DATA_WIDTH-1:0] req_wdata_in,
    output logic                         rsp_valid_out,
    output logic [NARROW_DATA_WIDTH-1:0] rsp_rdata_out,
    input  logic                         flush_in,
    output logic                         idle_out,
    output logic                         bram_clk_out,
    output logic                         bram_rst_out,
    output logic                         bram_en_out,
    output logic [WIDE_DATA_WIDTH/8-1:0] bram_we_out,
    output logic [ADDR_WIDTH-1:0]        bram_addr_out,
    output logic [WIDE_DATA_WIDTH-1:0]   bram_din_out,
    input  logic [WIDE_DATA_WIDTH-1:0]   bram_din_in
);

    state_t state, state_nx;

    logic                       flush_pend, flush_serv;
    logic                       rb_valid;
    logic [LINE_W-1:0]          rb_line, rd_line;
    logic [WIDE_DATA_WIDTH-1:0] rb_data;
    logic [1:0]                 wait_cnt;
    logic                       rd_accept, req_ready, wb_merge;

    logic                        wb_valid, wb_full_nx;
    logic [LINE_W-1:0]           wb_line;
    logic [WIDE_DATA_WIDTH-1:0]  wb_data;
    logic [LINE_BYTES-1:0]       wb_mask;

    logic [LINE_W-1:0] req_line;
    logic [2:0]        req_lane;
    logic              is_write, rb_hit, wb_same, rd_done;

    assign req_line = line_of(req_addr_in);
    assign req_lane = lane_of(req_addr_in);
    assign is_write = |req_we_in;
    assign rb_hit   = rb_valid && (rb_line == req_line);
    assign wb_same  = wb_valid && (wb_line == req_line);
    assign rd_done  = (state == RD_WAIT) && (wait_cnt == 2'(READ_LATENCY));

    bram_gather_wbuf u_wbuf (
        .clk       (bram_clk_in),
        .rstn      (bram_rstn_in),
        .merge     (wb_merge),
        .clear     (state == FLUSH),
        .wr_line   (req_line),
        .wr_lane   (req_lane),
        .wr_we     (req_we_in),
        .wr_data   (req_wdata_in),
        .buf_valid (wb_valid),
        .buf_line  (wb_line),
        .buf_data  (wb_data),
        .buf_mask  (wb_mask),
        .full_next (wb_full_nx)
    );

    // A pending flush outranks any request; misses that overlap the write line drain it first.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        wb_merge   = 1'b0;
        rd_accept  = 1'b0;
        flush_serv = 1'b0;
        case (state)
            IDLE: begin
                if (flush_pend) begin
                    flush_serv = 1'b1;
                    if (wb_valid) state_nx = FLUSH;
                end else if (req_valid_in) begin
                    if (is_write) begin
                        if (!wb_valid || wb_line == req_line) begin
                            req_ready = 1'b1;
                            wb_merge  = 1'b1;
                            if (wb_full_nx) state_nx = FLUSH;
                        end else begin
                            state_nx = FLUSH;
                        end
                    end else if (rb_hit) begin
                        req_ready = 1'b1;
                        rd_accept = 1'b1;
                    end else if (wb_same) begin
                        state_nx = FLUSH;
                    end else begin
                        state_nx = RD_ISSUE;
                    end
                end
            end
            FLUSH:    state_nx = IDLE;
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT:  if (rd_done) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge bram_clk_in) begin
        if (!bram_rstn_in) begin
            state         <= IDLE;
            flush_pend    <= 1'b0;
            rb_valid      <= 1'b0;
            wait_cnt      <= '0;
            rsp_valid_out <= 1'b0;
            rsp_rdata_out <= '0;
        end else begin
            state         <= state_nx;
            flush_pend    <= flush_in | (flush_pend & ~flush_serv);
            rsp_valid_out <= rd_accept;
            wait_cnt      <= (state == RD_WAIT) ? 2'(wait_cnt + 2'd1) : 2'd0;
            if (rd_accept) rsp_rdata_out <= rb_data[{req_lane, 4'b0} +: 16];
            if (state == IDLE && state_nx == RD_ISSUE) rd_line <= req_line;
            if (rd_done) begin
                rb_data  <= bram_din_in;
                rb_line  <= rd_line;
                rb_valid <= 1'b1;
            end else if (wb_merge && rb_hit) begin
                rb_data <= byte_merge(rb_data, req_wdata_in, strobe_mask(req_we_in, req_lane));
            end
        end
    end

    assign req_ready_out = req_ready & bram_rstn_in;
    assign idle_out      = (state == IDLE) && !wb_valid && !flush_pend;
    assign bram_clk_out  = bram_clk_in;
    assign bram_rst_out  = ~bram_rstn_in;
    assign bram_en_out   = (state == FLUSH) || (state == RD_ISSUE);
    assign bram_we_out   = (state == FLUSH) ? wb_mask : '0;
    assign bram_din_out  = wb_data;

    always_comb begin
        bram_addr_out = '0;
        if (state == FLUSH)    bram_addr_out = {wb_line, 4'b0};
        if (state == RD_ISSUE) bram_addr_out = {rd_line, 4'b0};
    end

endmodule

// File: tb/tb_bram_lane_gather.sv
// tb/tb_bram_lane_gather.sv - directed and randomized checks of bram_lane_gather against a flat memory model
module tb_bram_lane_gather;

    localparam int RL = 2;

    logic         clk = 1'b0;
    logic         rstn, req_valid, flush, idle, rsp_valid, req_ready;
    logic [1:0]   req_we;
    logic [39:0]  req_addr, bram_addr;
    logic [15:0]  req_wdata, rsp_rdata, bram_we;
    logic         bram_clk, bram_rst, bram_en;
    logic [127:0] bram_din, bram_dout;

    always #5 clk = ~clk;

    bram_lane_gather #(
        .ADDR_WIDTH(40), .WIDE_DATA_WIDTH(128), .NARROW_DATA_WIDTH(16), .READ_LATENCY(RL)
    ) dut (
        .bram_clk_in  (clk),       .bram_rstn_in (rstn),
        .req_valid_in (req_valid), .req_ready_out(req_ready),
        .req_we_in    (req_we),    .req_addr_in  (req_addr),
        .req_wdata_in (req_wdata), .rsp_valid_out(rsp_valid),
        .rsp_rdata_out(rsp_rdata), .flush_in     (flush),
        .idle_out     (idle),      .bram_clk_out (bram_clk),
        .bram_rst_out (bram_rst),  .bram_en_out  (bram_en),
        .bram_we_out  (bram_we),   .bram_addr_out(bram_addr),
        .bram_din_out (bram_din),  .bram_din_in  (bram_dout)
    );

    // BRAM model: 64 lines, two-cycle read latency, output holds between reads
    logic [127:0] bram_mem [0:63];
    logic [127:0] ref_mem  [0:63];
    logic         mem_init, rd_v1;
    logic [127:0] rd_p1, last_wdin;
    logic [39:0]  last_waddr, last_raddr;
    logic [15:0]  last_we;
    int           rd_cnt = 0, wr_cnt = 0;
    int           total = 0, passes = 0, fails = 0;

    function automatic logic [127:0] init_line(input int i);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[16*k +: 16] = (i == 16) ? 16'(k) : 16'(i * 256 + k * 17 + 4096);
        return l;
    endfunction

    function automatic logic [127:0] apply_we(input logic [127:0] old, input logic [127:0] din,
                                              input logic [15:0] we);
        logic [127:0] r;
        r = old;
        for (int b = 0; b < 16; b++) if (we[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) bram_mem[i] <= init_line(i);
        end else if (bram_en && bram_we != 16'h0) begin
            bram_mem[bram_addr[9:4]] <= apply_we(bram_mem[bram_addr[9:4]], bram_din, bram_we);
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= bram_addr;
            last_we    <= bram_we;
            last_wdin  <= bram_din;
        end
        rd_v1 <= bram_en && bram_we == 16'h0;
        rd_p1 <= bram_mem[bram_addr[9:4]];
        if (bram_en && bram_we == 16'h0) begin
            rd_cnt     <= rd_cnt + 1;
            last_raddr <= bram_addr;
        end
        if (rd_v1) bram_dout <= rd_p1;
    end

    function automatic logic [15:0] ref_word(input logic [39:0] a);
        return ref_mem[a[9:4]][16*a[3:1] +: 16];
    endfunction

    task automatic ref_write(input logic [1:0] we, input logic [39:0] a, input logic [15:0] wd);
        for (int b = 0; b < 2; b++)
            if (we[b]) ref_mem[a[9:4]][16*a[3:1] + 8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        fails++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    // Presents one request, holds it until accepted, and collects the read response if any.
    task automatic do_req(input logic [1:0] we, input logic [39:0] a, input logic [15:0] wd,
                          output int waits, output logic got, output logic [15:0] rdata);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        waits = 0; got = 1'b0; rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waits++;
            if (waits > 50) begin timeout("req_accept"); break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (we == 2'b00) begin
            @(negedge clk);
            got = rsp_valid; rdata = rsp_rdata;
        end else begin
            ref_write(we, a, wd);
        end
    endtask

    task automatic flush_pulse(output logic busy);
        int n;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        busy = !idle;
        n = 0;
        while (!idle) begin
            @(negedge clk);
            n++;
            if (n > 20) begin timeout("flush_idle"); break; end
        end
    endtask

    initial begin
        int w0, r0, waits, n;
        logic got, busy;
        logic [15:0] rd;
        logic [39:0] a;
        logic [1:0]  we;

        rstn = 1'b0; req_valid = 1'b0; req_we = 2'b00; req_addr = '0; req_wdata = '0;
        flush = 1'b0; mem_init = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_line(i);
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check("rst_bram_rst", bram_rst, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_bram_en", bram_en, 1'b0);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        check("post_rst_idle", idle, 1'b1);
        check("post_rst_ready", req_ready, 1'b0);
        check("post_rst_we", bram_we, 16'h0);
        check("post_rst_bram_rst", bram_rst, 1'b0);

        // Eight lane writes fill line 0 and trigger one full-line write
        w0 = wr_cnt;
        for (int i = 0; i < 8; i++) do_req(2'b11, 40'(2 * i), 16'hAAAA, waits, got, rd);
        @(negedge clk);
        check("full_en", bram_en, 1'b1);
        check("full_we", bram_we, 16'hFFFF);
        check("full_addr", bram_addr, 40'h0);
        check("full_din", bram_din, {8{16'hAAAA}});
        @(negedge clk);
        check("full_count", wr_cnt - w0, 1);

        // Partial line then a write to a different line
        do_req(2'b01, 40'h22, 16'h1234, waits, got, rd);
        w0 = wr_cnt;
        do_req(2'b11, 40'h40, 16'h5678, waits, got, rd);
        check("evict_waits", waits, 2);
        check("evict_count", wr_cnt - w0, 1);
        check("evict_addr", last_waddr, 40'h20);
        check("evict_we", last_we, 16'h0004);
        check("evict_byte", last_wdin[23:16], 8'h34);

        // Read miss then hit
        flush_pulse(busy);
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(2'b00, 40'h104, 16'h0, waits, got, rd);
        check("miss_latency", waits + 1, RL + 4);
        check("miss_rsp", got, 1'b1);
        check("miss_data", rd, 16'h0002);
        check("miss_reads", rd_cnt - r0, 1);
        check("miss_addr", last_raddr, 40'h100);
        do_req(2'b00, 40'h10E, 16'h0, waits, got, rd);
        check("hit_waits", waits, 0);
        check("hit_rsp", got, 1'b1);
        check("hit_data", rd, 16'h0007);
        check("hit_reads", rd_cnt - r0, 1);
        check("hit_writes", wr_cnt - w0, 0);

        // Read-after-write coherence through the read buffer
        do_req(2'b11, 40'h106, 16'hBEEF, waits, got, rd);
        r0 = rd_cnt;
        do_req(2'b00, 40'h106, 16'h0, waits, got, rd);
        check("raw_data", rd, 16'hBEEF);
        check("raw_reads", rd_cnt - r0, 0);
        do_req(2'b00, 40'h200, 16'h0, waits, got, rd);
        check("rd200_data", rd, ref_word(40'h200));
        w0 = wr_cnt;
        do_req(2'b11, 40'h300, 16'h00FF, waits, got, rd);
        check("evict100_waits", waits, 2);
        check("evict100_addr", last_waddr, 40'h100);
        check("evict100_we", last_we, 16'h00C0);
        check("evict100_data", last_wdin[63:48], 16'hBEEF);

        // Explicit flush drains the single-lane write
        w0 = wr_cnt;
        flush_pulse(busy);
        check("flush_busy", busy, 1'b1);
        check("flush_count", wr_cnt - w0, 1);
        check("flush_addr", last_waddr, 40'h300);
        check("flush_we", last_we, 16'h0003);
        check("flush_data", last_wdin[15:0], 16'h00FF);
        check("flush_idle", idle, 1'b1);

        // Random traffic against the flat memory model
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 15) == 0) flush_pulse(busy);
            n  = 8 * $urandom_range(0, 7) + $urandom_range(0, 1);
            a  = {30'(n), 6'(n), $urandom_range(0, 7) == 0 ? 4'h0 : 4'(2 * $urandom_range(0, 7))};
            a[39:10] = '0;
            we = 2'($urandom_range(0, 3));
            do_req(we, a, 16'($urandom), waits, got, rd);
            if (we == 2'b00) begin
                check("rand_rsp", got, 1'b1);
                check("rand_data", rd, ref_word(a));
            end
        end
        flush_pulse(busy);
        for (int i = 0; i < 64; i++) check("mem_line", bram_mem[i], ref_mem[i]);

        // Reset while a read waits for BRAM data
        do_req(2'b00, 40'h3E0, 16'h0, waits, got, rd);
        check("pre_rst_data", rd, ref_word(40'h3E0));
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 2'b00; req_addr = 40'h3D0;
        n = 0;
        forever begin
            @(negedge clk);
            if (bram_en) break;
            n++;
            if (n > 10) begin timeout("rd_issue"); break; end
        end
        @(posedge clk); #1;
        rstn = 1'b0; req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_ready", req_ready, 1'b0);
        check("mid_rst_rsp", rsp_valid, 1'b0);
        check("mid_rst_en", bram_en, 1'b0);
        check("mid_rst_we", bram_we, 16'h0);
        check("mid_rst_bram_rst", bram_rst, 1'b1);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        check("rel_idle", idle, 1'b1);
        r0 = rd_cnt;
        do_req(2'b00, 40'h3E0, 16'h0, waits, got, rd);
        check("rb_dropped_reads", rd_cnt - r0, 1);
        check("rb_dropped_data", rd, ref_word(40'h3E0));
        do_req(2'b00, 40'h3D2, 16'h0, waits, got, rd);
        check("reissue_reads", rd_cnt - r0, 2);
        check("reissue_data", rd, ref_word(40'h3D2));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
